// File: rtl/bcd_counter_chain_pkg.sv
// Shared constants and digit arithmetic for the cascaded modulo counter.
package counter_pkg;

   localparam int DIGIT_W = 4;

   // Terminal value of a digit that counts 0..modulus-1.
   function automatic logic [DIGIT_W-1:0] max_digit(input int modulus);
      return DIGIT_W'(modulus - 1);
   endfunction

   // Value a digit takes when it steps. Anything out of range (X or a
   // corrupted register) is pulled back to 0 rather than held.
   function automatic logic [DIGIT_W-1:0] next_digit(input logic [DIGIT_W-1:0] val,
                                                     input logic               up,
                                                     input int                 modulus);
      logic [DIGIT_W-1:0] w_res;
      if (int'(val) >= modulus) begin
         w_res = '0;
      end else if (up) begin
         w_res = (val == max_digit(modulus)) ? '0 : DIGIT_W'(val + 4'd1);
      end else begin
         w_res = (val == '0) ? max_digit(modulus) : DIGIT_W'(val - 4'd1);
      end
      return w_res;
   endfunction

endpackage

// File: rtl/bcd_counter_chain_if.sv
// Control and status bundle of the counter chain. The master drives the
// count controls; the counter (slave) returns the count and its flags.
interface bcd_counter_chain_if #(
   parameter int DIGITS = 4
) ();

   logic                  EN;
   logic                  UP;
   logic                  LOAD;
   logic [DIGITS*4-1:0]   LOAD_VAL;
   logic [DIGITS*4-1:0]   Q;
   logic                  TC;
   logic                  OVF;

   modport master (
      output EN, UP, LOAD, LOAD_VAL,
      input  Q, TC, OVF
   );

   modport slave (
      input  EN, UP, LOAD, LOAD_VAL,
      output Q, TC, OVF
   );

endinterface

// File: rtl/bcd_counter_chain_mod_digit.sv
// One modulo digit of the chain. Steps when i_step is high and passes the
// step on (carry up / borrow down) when it sits at its terminal value.
module mod_digit
   import counter_pkg::*;
#(
   parameter int MODULUS = 10
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_load,
   input  logic [DIGIT_W-1:0] i_load_nib,
   input  logic               i_step,
   input  logic               i_up,
   output logic [DIGIT_W-1:0] o_digit,
   output logic               o_step
);

   localparam logic [DIGIT_W-1:0] MAXD = max_digit(MODULUS);

   logic [DIGIT_W-1:0] r_digit;
   logic               w_at_term;

   // Terminal value depends on direction: top of range going up, zero going down.
   always_comb begin
      w_at_term = i_up ? (r_digit == MAXD) : (r_digit == '0);
   end

   // Digit register: reset, then load (illegal nibbles clear), then step.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_digit <= '0;
      end else if (i_load) begin
         r_digit <= (int'(i_load_nib) >= MODULUS) ? '0 : i_load_nib;
      end else if (i_step) begin
         r_digit <= next_digit(r_digit, i_up, MODULUS);
      end
   end

   assign o_digit = r_digit;
   assign o_step  = i_step & w_at_term;

endmodule

// File: rtl/bcd_counter_chain.sv
// Multi-digit synchronous modulo counter. Digits share one clock and are
// cascaded by a combinational step chain; the last step output is the
// terminal count, and a registered copy of it gives the wrap pulse.
module bcd_counter_chain
   import counter_pkg::*;
#(
   parameter int DIGITS  = 4,
   parameter int MODULUS = 10
) (
   input  logic             CLK,
   input  logic             RESET,
   bcd_counter_chain_if.slave bus
);

   logic [DIGITS:0]           w_step;
   logic [DIGITS*DIGIT_W-1:0] w_q;
   logic                      w_tc;
   logic                      r_ovf;

   // Digit 0 steps on every enabled cycle; each higher digit is gated by the
   // one below it, so the chain output is EN & all digits terminal.
   assign w_step[0] = bus.EN;

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      mod_digit #(
         .MODULUS (MODULUS)
      ) u_digit (
         .i_clk      (CLK),
         .i_rst      (RESET),
         .i_load     (bus.LOAD),
         .i_load_nib (bus.LOAD_VAL[g*DIGIT_W +: DIGIT_W]),
         .i_step     (w_step[g]),
         .i_up       (bus.UP),
         .o_digit    (w_q[g*DIGIT_W +: DIGIT_W]),
         .o_step     (w_step[g+1])
      );
   end

   assign w_tc = w_step[DIGITS];

   // Wrap pulse: last cycle's terminal count, suppressed by reset or load.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_ovf <= 1'b0;
      end else if (bus.LOAD) begin
         r_ovf <= 1'b0;
      end else begin
         r_ovf <= w_tc;
      end
   end

   assign bus.Q   = w_q;
   assign bus.TC  = w_tc;
   assign bus.OVF = r_ovf;

endmodule

// File: doc/bcd_counter_chain.md
Name: bcd_counter_chain

Overview:
Parametrised synchronous multi-digit modulo counter. It is the generalised successor of the team's single 4-bit toggle-style counter.
Adds configurable digit count and per-digit modulus, up/down direction, parallel load, count enable, a terminal-count output and an overflow flag.
Feeds display/timebase logic. Digits are cascaded with a synchronous carry/borrow chain, so all flops share one clock and there is no ripple clocking.

Parameters:
DIGITS, 4, number of cascaded digits (1..8)
MODULUS, 10, per-digit modulus (2..16); each digit counts 0..MODULUS-1
DIGIT_W, 4, bits per digit (localparam, fixed at 4)

Ports:
CLK  in  1  clock, all state updates on rising edge
RESET  in  1  synchronous, active-high reset
EN  in  1  count enable; one step per cycle while high
UP  in  1  direction: 1 = count up, 0 = count down
LOAD  in  1  parallel load strobe
LOAD_VAL  in  DIGITS*4  load value, digit 0 in bits [3:0]
Q  out  DIGITS*4  current count, digit 0 least significant in bits [3:0]
TC  out  1  terminal count, combinational
OVF  out  1  registered one-cycle wrap pulse

Behaviour:
- Priority per rising edge: RESET > LOAD > EN. With none of these active, hold all state.
- RESET=1: Q=0 and OVF=0 at the next edge. Reset is synchronous only; no asynchronous path.
- LOAD=1 (RESET=0): each digit takes its LOAD_VAL nibble. A nibble >= MODULUS loads as 0. OVF=0 that cycle. EN is ignored.
- EN=1, UP=1 (count up):
  - digit 0 always steps;
  - digit i steps only when all lower digits equal MODULUS-1;
  - a digit at MODULUS-1 that steps wraps to 0.
- EN=1, UP=0 (count down):
  - digit i steps only when all lower digits equal 0;
  - a digit at 0 that steps wraps to MODULUS-1.
- Carry/borrow chain: combinational enable chain, equivalent to T-input gating. One-cycle latency from EN to Q.
- TC = EN & (all digits == MODULUS-1 when UP=1, or all digits == 0 when UP=0). TC is combinational from state, EN and UP.
- OVF: registered; equals TC from the previous cycle, unless that cycle had RESET or LOAD.
- Whole-chain wrap: up from all-(MODULUS-1) gives all-0; down from all-0 gives all-(MODULUS-1); OVF=1 for exactly one cycle after.
- UP may change on any cycle and takes effect on the same edge; no extra state.
- Out-of-range digits (only possible via X or a future bug) step to 0 on the next enabled step of that digit. They are never held.
- Reset mid-count: the count is lost, the previous TC is not reported, and OVF=0.
- No internal FSM beyond per-digit registers and the OVF flop. The total flop count is DIGITS*4 + 1.

Decomposition:
- Package counter_pkg holds:
  - DIGIT_W = 4;
  - a function max_digit(MODULUS) returning MODULUS-1;
  - a function next_digit(val, up, modulus) implementing the wrap rules.
- Sub-module mod_digit implements one digit:
  - inputs: CLK, RESET, LOAD, load nibble, step_in, UP;
  - outputs: digit value, step_out (step_in & digit at its terminal value);
  - instantiated DIGITS times via generate.
- Top level only chains step_out to step_in and generates TC and OVF.

Test Plan:
- Reset, then EN=1, UP=1 for 10000 cycles, default params: Q steps 0000..9999 in BCD. At Q=9999, TC=1. Next edge gives Q=0000 and OVF=1 for one cycle.
- Ripple check, UP=1: LOAD_VAL=0x1999 gives Q=0x1999. One EN cycle gives Q=0x2000, TC=0, OVF=0. Digits never show A..F.
- Down wrap: LOAD 0x0000, UP=0, EN=1. TC=1 immediately. Next edge gives Q=0x9999 and OVF=1. The next step gives 0x9998.
- Priority: on the same cycle assert RESET=1, LOAD=1 (0x4321) and EN=1. Next Q=0x0000. Then LOAD=1 with EN=1 gives Q=0x4321, no increment.
- Illegal load and hold: LOAD_VAL=0x0C0A gives Q=0x0000. Dropping EN=0 mid-count holds Q unchanged for 5 cycles, with TC=0.
- Params DIGITS=2, MODULUS=6, UP=1 from 0: sequence 00..55 over 36 cycles, then wrap to 00 with OVF pulse. Toggling UP at 0x23 gives 0x22 on the next edge.
